// File: rtl/addr_remap_if.sv
// Bundle of configuration, address-gating, response-monitor and status
// signals between the address remap controller and its surroundings.
interface addr_remap_if #(
    parameter int BASE_W = 5,
    parameter int CNT_W  = 5
);
    logic              cfg_valid;
    logic [BASE_W-1:0] cfg_base;
    logic              cfg_ready;
    logic              cfg_done;
    logic [BASE_W-1:0] map_base;
    logic              s_awvalid;
    logic              s_awready;
    logic              m_awvalid;
    logic              m_awready;
    logic              s_arvalid;
    logic              s_arready;
    logic              m_arvalid;
    logic              m_arready;
    logic              bvalid;
    logic              bready;
    logic              rvalid;
    logic              rready;
    logic              rlast;
    logic [CNT_W-1:0]  wr_outst;
    logic [CNT_W-1:0]  rd_outst;
    logic              busy;

    // Controller side
    modport slave (
        input  cfg_valid, cfg_base,
        output cfg_ready, cfg_done, map_base,
        input  s_awvalid, output s_awready,
        output m_awvalid, input  m_awready,
        input  s_arvalid, output s_arready,
        output m_arvalid, input  m_arready,
        input  bvalid, bready, rvalid, rready, rlast,
        output wr_outst, rd_outst, busy
    );

    // Environment side
    modport master (
        output cfg_valid, cfg_base,
        input  cfg_ready, cfg_done, map_base,
        output s_awvalid, input  s_awready,
        input  m_awvalid, output m_awready,
        output s_arvalid, input  s_arready,
        input  m_arvalid, output m_arready,
        output bvalid, bready, rvalid, rready, rlast,
        input  wr_outst, rd_outst, busy
    );
endinterface

// File: rtl/addr_remap_ctrl.sv
// Address-window remap controller: supplies map_base to the AXI address
// mapper, drains outstanding traffic before a base change takes effect and
// caps the number of outstanding reads and writes per direction.
module addr_remap_ctrl #(
    parameter int                BASE_W     = 5,
    parameter logic [BASE_W-1:0] RESET_BASE = 5'b10000,
    parameter int                MAX_OUTST  = 16,
    parameter int                CNT_W      = 5
) (
    input  logic         aclk,
    input  logic         aresetn,
    addr_remap_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        SWITCH = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTST);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t            state_r;
    state_t            state_nxt_s;
    logic              live_r;
    logic [BASE_W-1:0] pend_base_r;
    logic [BASE_W-1:0] map_base_r;
    logic              cfg_done_r;
    logic [CNT_W-1:0]  wr_cnt_r;
    logic [CNT_W-1:0]  rd_cnt_r;
    logic              aw_hold_r;
    logic              ar_hold_r;

    logic              aw_open_s;
    logic              ar_open_s;
    logic              aw_hs_s;
    logic              ar_hs_s;
    logic              b_hs_s;
    logic              r_end_s;
    logic              accept_s;
    logic              drained_s;

    // Saturating up/down step; simultaneous inc and dec cancel out.
    function automatic logic [CNT_W-1:0] next_count(
        input logic [CNT_W-1:0] cnt,
        input logic             inc,
        input logic             dec
    );
        logic [CNT_W-1:0] res;
        res = cnt;
        if (inc && !dec) begin
            if (cnt != CNT_MAX) begin
                res = cnt + CNT_ONE;
            end else begin
                res = cnt;
            end
        end else if (dec && !inc) begin
            if (cnt != CNT_ZERO) begin
                res = cnt - CNT_ONE;
            end else begin
                res = cnt;
            end
        end else begin
            res = cnt;
        end
        return res;
    endfunction

    // Channel gating: open in IDLE below the cap, or while a stalled
    // request must be kept alive until its handshake.
    always_comb begin
        aw_open_s = ((state_r == IDLE) && (wr_cnt_r < CNT_MAX)) || aw_hold_r;
        ar_open_s = ((state_r == IDLE) && (rd_cnt_r < CNT_MAX)) || ar_hold_r;
        aw_hs_s   = bus.s_awvalid & aw_open_s & bus.m_awready;
        ar_hs_s   = bus.s_arvalid & ar_open_s & bus.m_arready;
        b_hs_s    = bus.bvalid & bus.bready;
        r_end_s   = bus.rvalid & bus.rready & bus.rlast;
        drained_s = (wr_cnt_r == CNT_ZERO) && (rd_cnt_r == CNT_ZERO) &&
                    !aw_hold_r && !ar_hold_r;
    end

    assign bus.m_awvalid = bus.s_awvalid & aw_open_s;
    assign bus.s_awready = bus.m_awready & aw_open_s;
    assign bus.m_arvalid = bus.s_arvalid & ar_open_s;
    assign bus.s_arready = bus.m_arready & ar_open_s;

    assign bus.cfg_ready = (state_r == IDLE) & live_r;
    assign bus.cfg_done  = cfg_done_r;
    assign bus.map_base  = map_base_r;
    assign bus.busy      = (state_r != IDLE);
    assign bus.wr_outst  = wr_cnt_r;
    assign bus.rd_outst  = rd_cnt_r;

    // Next-state logic for the drain/switch sequence.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.cfg_valid && live_r) begin
                    state_nxt_s = DRAIN;
                    accept_s    = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            DRAIN: begin
                if (drained_s) begin
                    state_nxt_s = SWITCH;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            SWITCH: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register, pending/active base and the applied pulse; the new
    // base is loaded on entry to SWITCH so it is visible during SWITCH.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_r     <= IDLE;
            live_r      <= 1'b0;
            pend_base_r <= RESET_BASE;
            map_base_r  <= RESET_BASE;
            cfg_done_r  <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            live_r     <= 1'b1;
            cfg_done_r <= (state_nxt_s == SWITCH);
            if (accept_s) begin
                pend_base_r <= bus.cfg_base;
            end else begin
                pend_base_r <= pend_base_r;
            end
            if (state_nxt_s == SWITCH) begin
                map_base_r <= pend_base_r;
            end else begin
                map_base_r <= map_base_r;
            end
        end
    end

    // Outstanding-transaction counters.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_cnt_r <= CNT_ZERO;
            rd_cnt_r <= CNT_ZERO;
        end else begin
            wr_cnt_r <= next_count(wr_cnt_r, aw_hs_s, b_hs_s);
            rd_cnt_r <= next_count(rd_cnt_r, ar_hs_s, r_end_s);
        end
    end

    // Hold flags keep an already-presented valid asserted until accepted.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_hold_r <= 1'b0;
            ar_hold_r <= 1'b0;
        end else begin
            if (aw_hs_s) begin
                aw_hold_r <= 1'b0;
            end else if (bus.m_awvalid && !bus.m_awready) begin
                aw_hold_r <= 1'b1;
            end else begin
                aw_hold_r <= aw_hold_r;
            end
            if (ar_hs_s) begin
                ar_hold_r <= 1'b0;
            end else if (bus.m_arvalid && !bus.m_arready) begin
                ar_hold_r <= 1'b1;
            end else begin
                ar_hold_r <= ar_hold_r;
            end
        end
    end

endmodule

// File: tb/tb_addr_remap_ctrl.sv
// Self-checking bench for addr_remap_ctrl: directed scenarios followed by
// randomized traffic, all compared against a behavioural reference model.
module tb_addr_remap_ctrl;

    logic aclk;
    logic aresetn;
    int   n_cmp;
    int   n_bad;

    addr_remap_if #(.BASE_W(5), .CNT_W(5)) bus ();

    addr_remap_ctrl dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Reference model state: counts as plain integers, the configuration
    // request seen as "waiting for drain" and "just applied".
    int ref_wr, ref_rd, ref_base, ref_pend;
    bit ref_aw_stall, ref_ar_stall, ref_drain, ref_applied, ref_live;

    // Outputs sampled mid-cycle by the last step.
    int smp_m_awvalid, smp_s_awready, smp_m_arvalid, smp_s_arready;
    int smp_cfg_ready, smp_cfg_done, smp_busy, smp_map_base;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int clamp(input int v);
        if (v < 0) return 0;
        if (v > 16) return 16;
        return v;
    endfunction

    task automatic ref_reset();
        ref_wr = 0; ref_rd = 0; ref_base = 16; ref_pend = 16;
        ref_aw_stall = 1'b0; ref_ar_stall = 1'b0;
        ref_drain = 1'b0; ref_applied = 1'b0; ref_live = 1'b0;
    endtask

    // One clock cycle: compare outputs mid-cycle, advance the model, then
    // move to just after the next rising edge.
    task automatic step();
        bit quiet, aw_ok, ar_ok, aw_hs, ar_hs, b_hs, r_end, drained;
        #3;
        if (!aresetn) ref_reset();
        quiet = !ref_drain && !ref_applied;
        aw_ok = (quiet && ref_wr < 16) || ref_aw_stall;
        ar_ok = (quiet && ref_rd < 16) || ref_ar_stall;
        smp_m_awvalid = int'(bus.m_awvalid);
        smp_s_awready = int'(bus.s_awready);
        smp_m_arvalid = int'(bus.m_arvalid);
        smp_s_arready = int'(bus.s_arready);
        smp_cfg_ready = int'(bus.cfg_ready);
        smp_cfg_done  = int'(bus.cfg_done);
        smp_busy      = int'(bus.busy);
        smp_map_base  = int'(bus.map_base);
        chk("m_awvalid", smp_m_awvalid, int'(bus.s_awvalid && aw_ok));
        chk("s_awready", smp_s_awready, int'(bus.m_awready && aw_ok));
        chk("m_arvalid", smp_m_arvalid, int'(bus.s_arvalid && ar_ok));
        chk("s_arready", smp_s_arready, int'(bus.m_arready && ar_ok));
        chk("cfg_ready", smp_cfg_ready, int'(ref_live && quiet));
        chk("cfg_done",  smp_cfg_done,  int'(ref_applied));
        chk("busy",      smp_busy,      int'(!quiet));
        chk("map_base",  smp_map_base,  ref_base);
        chk("wr_outst",  int'(bus.wr_outst), ref_wr);
        chk("rd_outst",  int'(bus.rd_outst), ref_rd);
        if (aresetn) begin
            aw_hs   = bus.s_awvalid && aw_ok && bus.m_awready;
            ar_hs   = bus.s_arvalid && ar_ok && bus.m_arready;
            b_hs    = bus.bvalid && bus.bready;
            r_end   = bus.rvalid && bus.rready && bus.rlast;
            drained = ref_wr == 0 && ref_rd == 0 && !ref_aw_stall && !ref_ar_stall;
            ref_wr = clamp(ref_wr + int'(aw_hs) - int'(b_hs));
            ref_rd = clamp(ref_rd + int'(ar_hs) - int'(r_end));
            if (aw_hs) ref_aw_stall = 1'b0;
            else if (bus.s_awvalid && aw_ok) ref_aw_stall = 1'b1;
            if (ar_hs) ref_ar_stall = 1'b0;
            else if (bus.s_arvalid && ar_ok) ref_ar_stall = 1'b1;
            if (ref_applied) begin
                ref_applied = 1'b0;
            end else if (ref_drain && drained) begin
                ref_drain = 1'b0; ref_applied = 1'b1; ref_base = ref_pend;
            end else if (!ref_drain && ref_live && bus.cfg_valid) begin
                ref_drain = 1'b1; ref_pend = int'(bus.cfg_base);
            end
            ref_live = 1'b1;
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.cfg_valid = 1'b0; bus.cfg_base = 5'd0;
        bus.s_awvalid = 1'b0; bus.m_awready = 1'b0;
        bus.s_arvalid = 1'b0; bus.m_arready = 1'b0;
        bus.bvalid = 1'b0; bus.bready = 1'b0;
        bus.rvalid = 1'b0; bus.rready = 1'b0; bus.rlast = 1'b0;
    endtask

    initial begin
        int done_at, busy_cnt;
        n_cmp = 0; n_bad = 0;
        aresetn = 1'b0;
        idle_inputs();
        ref_reset();
        @(posedge aclk); #1;

        // 1: reset for 3 cycles, then a passthrough AW
        for (int i = 0; i < 3; i++) step();
        aresetn = 1'b1;
        step();
        bus.s_awvalid = 1'b1; bus.m_awready = 1'b1;
        step();
        chk("t1_m_awvalid", smp_m_awvalid, 1);
        chk("t1_cfg_ready", smp_cfg_ready, 1);
        chk("t1_map_base", smp_map_base, 16);
        bus.s_awvalid = 1'b0;
        chk("t1_wr_outst", int'(bus.wr_outst), 1);
        bus.bvalid = 1'b1; bus.bready = 1'b1;
        step();
        bus.bvalid = 1'b0;

        // 2: base change with no traffic
        bus.cfg_valid = 1'b1; bus.cfg_base = 5'b10001;
        step();
        bus.cfg_valid = 1'b0;
        done_at = 0; busy_cnt = 0;
        for (int i = 1; i <= 4; i++) begin
            step();
            if (smp_cfg_done == 1) done_at = i;
            busy_cnt += smp_busy;
        end
        chk("t2_done_at", done_at, 2);
        chk("t2_busy_cycles", busy_cnt, 2);
        chk("t2_map_base", int'(bus.map_base), 17);

        // 3: drain with 3 read bursts and 2 writes outstanding
        bus.s_arvalid = 1'b1; bus.m_arready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        bus.s_arvalid = 1'b0; bus.s_awvalid = 1'b1;
        for (int i = 0; i < 2; i++) step();
        bus.s_awvalid = 1'b0;
        bus.cfg_valid = 1'b1; bus.cfg_base = 5'b00011;
        step();
        bus.cfg_valid = 1'b0;
        bus.s_arvalid = 1'b1; bus.s_awvalid = 1'b1;
        step();
        chk("t3_s_arready", smp_s_arready, 0);
        chk("t3_s_awready", smp_s_awready, 0);
        bus.rvalid = 1'b1; bus.rready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            bus.rlast = ((i % 4) == 3);
            step();
        end
        bus.rvalid = 1'b0; bus.rlast = 1'b0;
        chk("t3_rd_zero", int'(bus.rd_outst), 0);
        bus.bvalid = 1'b1;
        step();
        chk("t3_base_hold1", int'(bus.map_base), 17);
        step();
        bus.bvalid = 1'b0;
        chk("t3_base_hold2", int'(bus.map_base), 17);
        step();
        bus.s_arvalid = 1'b0; bus.s_awvalid = 1'b0;
        chk("t3_base_new", int'(bus.map_base), 3);
        chk("t3_done", int'(bus.cfg_done), 1);
        step();

        // 4: stalled AW when the drain starts
        bus.s_awvalid = 1'b1; bus.m_awready = 1'b0;
        bus.cfg_valid = 1'b1; bus.cfg_base = 5'b00100;
        step();
        bus.cfg_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4_m_awvalid_held", smp_m_awvalid, 1);
        end
        bus.m_awready = 1'b1;
        step();
        bus.s_awvalid = 1'b0;
        chk("t4_wr_rise", int'(bus.wr_outst), 1);
        chk("t4_busy", int'(bus.busy), 1);
        bus.bvalid = 1'b1;
        step();
        bus.bvalid = 1'b0;
        step();
        chk("t4_map_base", int'(bus.map_base), 4);
        step();

        // 5: counter cap and simultaneous AW/B
        bus.s_awvalid = 1'b1;
        for (int i = 0; i < 16; i++) step();
        chk("t5_full", int'(bus.wr_outst), 16);
        step();
        chk("t5_blocked", smp_s_awready, 0);
        bus.s_awvalid = 1'b0; bus.bvalid = 1'b1;
        step();
        chk("t5_after_b", int'(bus.wr_outst), 15);
        bus.s_awvalid = 1'b1;
        step();
        chk("t5_simul", int'(bus.wr_outst), 15);
        bus.bvalid = 1'b0;
        step();
        chk("t5_refill", int'(bus.wr_outst), 16);
        bus.s_awvalid = 1'b0; bus.bvalid = 1'b1;
        for (int i = 0; i < 16; i++) step();
        bus.bvalid = 1'b0;
        chk("t5_empty", int'(bus.wr_outst), 0);

        // 6: reset while draining with two reads outstanding
        bus.s_arvalid = 1'b1;
        for (int i = 0; i < 2; i++) step();
        bus.s_arvalid = 1'b0;
        bus.cfg_valid = 1'b1; bus.cfg_base = 5'b01010;
        step();
        bus.cfg_valid = 1'b0;
        step();
        chk("t6_busy", int'(bus.busy), 1);
        chk("t6_rd", int'(bus.rd_outst), 2);
        aresetn = 1'b0;
        step();
        chk("t6_base", int'(bus.map_base), 16);
        chk("t6_rd_clr", int'(bus.rd_outst), 0);
        chk("t6_idle", int'(bus.busy), 0);
        aresetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t6_no_done", smp_cfg_done, 0);
        end

        // Randomized traffic and configuration requests
        for (int i = 0; i < 3000; i++) begin
            bus.cfg_valid = ($urandom_range(0, 19) == 0);
            bus.cfg_base  = 5'($urandom_range(0, 31));
            bus.s_awvalid = $urandom_range(0, 1) == 1;
            bus.m_awready = $urandom_range(0, 3) != 0;
            bus.s_arvalid = $urandom_range(0, 1) == 1;
            bus.m_arready = $urandom_range(0, 3) != 0;
            bus.bvalid    = $urandom_range(0, 1) == 1;
            bus.bready    = $urandom_range(0, 3) != 0;
            bus.rvalid    = $urandom_range(0, 1) == 1;
            bus.rready    = $urandom_range(0, 3) != 0;
            bus.rlast     = $urandom_range(0, 1) == 1;
            step();
        end
        idle_inputs();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
